decrypt_capture: RTL and testbench

DECRYPT_CAPTURE -- requirements
Module: decrypt_capture

---
 rtl/decrypt_capture_pkg.sv | 10 +
 rtl/decrypt_capture_fifo.sv | 51 +++++
 rtl/decrypt_capture.sv | 72 +++++++
 tb/tb_decrypt_capture.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/decrypt_capture_pkg.sv
// Shared sizing constants for the decrypt capture buffer.
package decrypt_capture_pkg;

    localparam int unsigned DATA_WIDTH_C  = 32;
    localparam int unsigned FIFO_DEPTH_C  = 8;
    localparam int unsigned TOTAL_WIDTH_C = 16;

    localparam logic [TOTAL_WIDTH_C-1:0] TOTAL_MAX_C = '1;

endpackage : decrypt_capture_pkg

// File: rtl/decrypt_capture_fifo.sv
// Show-ahead FIFO storage with extra-MSB pointers. The caller guarantees push only
// when there is room (or a pop happens on the same edge) and pop only when not empty.
module capture_fifo #(
    parameter int unsigned data_width_g = 32,
    parameter int unsigned fifo_depth_g = 8,
    localparam int unsigned AW_C = $clog2(fifo_depth_g)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [data_width_g-1:0] wdata_i,
    output logic [data_width_g-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [AW_C:0]         count_o
);

    logic [data_width_g-1:0] mem_q [fifo_depth_g];
    logic [AW_C:0]           wr_ptr_q, wr_ptr_d;
    logic [AW_C:0]           rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + (AW_C+1)'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + (AW_C+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW_C-1:0]] <= wdata_i;
    end

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW_C] != rd_ptr_q[AW_C]) &&
                     (wr_ptr_q[AW_C-1:0] == rd_ptr_q[AW_C-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW_C-1:0]];

endmodule : capture_fifo

// File: rtl/decrypt_capture.sv
// Captures decrypter output words into a small FIFO with a sticky drop flag
// and a saturating accepted-word counter.
module decrypt_capture
    import decrypt_capture_pkg::*;
#(
    parameter int unsigned data_width_g = DATA_WIDTH_C,
    parameter int unsigned fifo_depth_g = FIFO_DEPTH_C
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              valid_in,
    input  logic [data_width_g-1:0]           decrypted_in,
    input  logic                              rd_ready_in,
    output logic                              rd_valid_out,
    output logic [data_width_g-1:0]           rd_data_out,
    output logic [$clog2(fifo_depth_g):0]     count_out,
    output logic                              overflow_out,
    input  logic                              clear_ovf_in,
    output logic [TOTAL_WIDTH_C-1:0]          total_out
);

    logic full, empty, push, pop, drop;
    logic overflow_q, overflow_d;
    logic [TOTAL_WIDTH_C-1:0] total_q, total_d;

    // A full FIFO still accepts when the head leaves on the same edge.
    assign pop  = rd_ready_in & ~empty;
    assign push = valid_in & (~full | pop);
    assign drop = valid_in & full & ~pop;

    capture_fifo #(
        .data_width_g (data_width_g),
        .fifo_depth_g (fifo_depth_g)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (decrypted_in),
        .rdata_o (rd_data_out),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_out)
    );

    // A drop on the same edge as a clear keeps the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (drop)              overflow_d = 1'b1;
        else if (clear_ovf_in) overflow_d = 1'b0;
    end

    always_comb begin
        total_d = total_q;
        if (push && (total_q != TOTAL_MAX_C)) total_d = total_q + TOTAL_WIDTH_C'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            total_q    <= '0;
        end else begin
            overflow_q <= overflow_d;
            total_q    <= total_d;
        end
    end

    assign rd_valid_out = ~empty;
    assign overflow_out = overflow_q;
    assign total_out    = total_q;

endmodule : decrypt_capture

// File: tb/tb_decrypt_capture.sv
// Directed bench for decrypt_capture: vector table plus hand sequences.
module tb_decrypt_capture;
    import decrypt_capture_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH_C) + 1;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     valid_in;
    logic [DATA_WIDTH_C-1:0]  decrypted_in;
    logic                     rd_ready_in;
    logic                     rd_valid_out;
    logic [DATA_WIDTH_C-1:0]  rd_data_out;
    logic [CW-1:0]            count_out;
    logic                     overflow_out;
    logic                     clear_ovf_in;
    logic [TOTAL_WIDTH_C-1:0] total_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decrypt_capture dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .decrypted_in (decrypted_in),
        .rd_ready_in  (rd_ready_in),
        .rd_valid_out (rd_valid_out),
        .rd_data_out  (rd_data_out),
        .count_out    (count_out),
        .overflow_out (overflow_out),
        .clear_ovf_in (clear_ovf_in),
        .total_out    (total_out)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        c;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ec;
        logic        eo;
        logic [15:0] et;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] ed,
                             input logic [3:0] ec, input logic eo, input logic [15:0] et);
        chk({tag, ".valid"}, 32'(rd_valid_out), 32'(ev));
        chk({tag, ".data"},  rd_data_out, ed);
        chk({tag, ".count"}, 32'(count_out), 32'(ec));
        chk({tag, ".ovf"},   32'(overflow_out), 32'(eo));
        chk({tag, ".total"}, 32'(total_out), 32'(et));
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic c);
        valid_in     = v;
        decrypted_in = d;
        rd_ready_in  = r;
        clear_ovf_in = c;
    endtask

    // Drive at the falling edge, let one rising edge pass, sample 1 time unit later.
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic c);
        @(negedge clk);
        drive(v, d, r, c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(logic v, logic [31:0] d, logic r, logic c,
                                logic ev, logic [31:0] ed, logic [3:0] ec, logic eo, logic [15:0] et);
        vec_t x;
        x.v = v; x.d = d; x.r = r; x.c = c;
        x.ev = ev; x.ed = ed; x.ec = ec; x.eo = eo; x.et = et;
        return x;
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0);

        vecs[0] = mk(1, 32'hDEAD_BEEF, 0, 0, 1, 32'hDEAD_BEEF, 1, 0, 1);
        vecs[1] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++)
            vecs[1+i] = mk(1, 32'(i), 0, 0, 1, 32'd1, 4'(i), 0, 16'(1+i));
        vecs[10] = mk(1, 32'd9,  0, 0, 1, 32'd1, 8, 1, 9);
        vecs[11] = mk(1, 32'd10, 0, 1, 1, 32'd1, 8, 1, 9);
        vecs[12] = mk(0, 0, 0, 1, 1, 32'd1, 8, 0, 9);
        for (int k = 1; k <= 8; k++)
            vecs[12+k] = mk(0, 0, 1, 0, (k < 8), (k < 8) ? 32'(k+1) : 32'd0, 4'(8-k), 0, 9);
        vecs[21] = mk(0, 0, 1, 0, 0, 0, 0, 0, 9);
        vecs[22] = mk(0, 0, 1, 1, 0, 0, 0, 0, 9);

        #1;
        check_all("reset_async", 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // No bypass: a word offered to an empty FIFO is not visible in the same cycle.
        drive(1, 32'h1234_5678, 0, 0);
        #1;
        chk("no_bypass.valid", 32'(rd_valid_out), 32'd0);
        drive(0, 0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c);
            check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec, vecs[i].eo, vecs[i].et);
        end

        // Full FIFO with simultaneous push and pop: accepted, no overflow, order kept.
        do_reset();
        for (int i = 1; i <= 8; i++) step(1, 32'(i), 0, 0);
        step(1, 32'd9, 1, 0);
        check_all("full_pushpop", 1, 32'd2, 8, 0, 9);
        for (int k = 2; k <= 9; k++) begin
            chk($sformatf("full_drain%0d", k), rd_data_out, 32'(k));
            step(0, 0, 1, 0);
        end
        check_all("full_drained", 0, 0, 0, 0, 9);

        // count=1 with simultaneous push and pop.
        step(1, 32'hA, 0, 0);
        step(1, 32'hB, 1, 0);
        check_all("cnt1_pushpop", 1, 32'hB, 1, 0, 11);

        // Streaming then an asynchronous reset in the middle of a cycle.
        do_reset();
        step(1, 32'd100, 1, 0);
        check_all("stream0", 1, 32'd100, 1, 0, 1);
        for (int i = 1; i < 20; i++) begin
            step(1, 32'(100 + i), 1, 0);
            chk($sformatf("stream%0d.data", i), rd_data_out, 32'(100 + i));
            chk($sformatf("stream%0d.count", i), 32'(count_out), 32'd1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all("midreset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'd500, 0, 0);
        @(posedge clk);
        #1;
        check_all("after_release", 1, 32'd500, 1, 0, 1);

        // Saturation of the accepted-word counter.
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            drive(1, 32'(i), 1, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0);
        chk("total_65535", 32'(total_out), 32'h0000_FFFF);
        step(1, 32'hCAFE, 1, 0);
        chk("total_sat", 32'(total_out), 32'h0000_FFFF);
        chk("total_sat.data", rd_data_out, 32'hCAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_decrypt_capture
